int_ctrl: RTL

//  Interrupt/boot sequencer that drives the PC-select mux's forced-vector path (int_sig, d3).

---
 rtl/cpu_pkg.sv | 43 ++++
 rtl/int_edge_latch.sv | 28 ++
 rtl/int_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt sequencer state encoding, vector addresses, CCR layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    // Default datapath and flag widths
    localparam int AW_DEF = 8;
    localparam int FW_DEF = 4;

    // Memory locations that hold the boot and interrupt vectors
    localparam logic [7:0] RST_VADDR_DEF = 8'h00;
    localparam logic [7:0] INT_VADDR_DEF = 8'h01;

    // CCR bit positions (Z,N,C,V from MSB down)
    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    // Sequencer state encoding
    localparam logic [2:0] ST_BOOT_ENC   = 3'd0;
    localparam logic [2:0] ST_IDLE_ENC   = 3'd1;
    localparam logic [2:0] ST_FETCH_ENC  = 3'd2;
    localparam logic [2:0] ST_VWAIT_ENC  = 3'd3;
    localparam logic [2:0] ST_REDIR_ENC  = 3'd4;
    localparam logic [2:0] ST_RETURN_ENC = 3'd5;

    typedef enum logic [2:0] {
        ST_BOOT   = ST_BOOT_ENC,
        ST_IDLE   = ST_IDLE_ENC,
        ST_FETCH  = ST_FETCH_ENC,
        ST_VWAIT  = ST_VWAIT_ENC,
        ST_REDIR  = ST_REDIR_ENC,
        ST_RETURN = ST_RETURN_ENC
    } state_t;

    // Which event started the current vector fetch
    typedef enum logic {
        SRC_BOOT = 1'b0,
        SRC_INT  = 1'b1
    } src_t;

endpackage

// File: rtl/int_edge_latch.sv
// Rising-edge detector on intr_in with a sticky pending flag.
// Latency: pending rises one cycle after the cycle intr_in first goes high.
// Backpressure: pending holds until clr; a new edge in the clr cycle keeps it set.
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic intr_in,
    input  logic clr,
    output logic pending
);

    logic intr_prev;
    logic rise;

    assign rise = intr_in & ~intr_prev;

    // Track previous intr_in; set on an edge, clear on request, set wins over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_prev <= 1'b0;
            pending   <= 1'b0;
        end else begin
            intr_prev <= intr_in;
            pending   <= rise | (pending & ~clr);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Boot/interrupt sequencer: fetches a vector from memory and forces the PC mux for one cycle.
// Latency: boot REDIR 2 cycles after reset release; interrupt REDIR 4 cycles after intr_in rises.
// Backpressure: stall/branch_pend hold the request in IDLE; pending is never dropped.
module int_ctrl
    import cpu_pkg::*;
#(
    parameter int            AW        = AW_DEF,
    parameter int            FW        = FW_DEF,
    parameter logic [AW-1:0] RST_VADDR = AW'(RST_VADDR_DEF),
    parameter logic [AW-1:0] INT_VADDR = AW'(INT_VADDR_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          intr_in,
    input  logic          stall,
    input  logic          branch_pend,
    input  logic [AW-1:0] pc_next,
    input  logic [FW-1:0] flags_in,
    input  logic          rti,
    input  logic [AW-1:0] vec_rdata,
    output logic          vec_rd,
    output logic [AW-1:0] vec_raddr,
    output logic          pc_hold,
    output logic          int_sig,
    output logic [AW-1:0] int_vec,
    output logic          flush,
    output logic [AW-1:0] ret_pc,
    output logic [FW-1:0] flags_out,
    output logic          flags_rst,
    output logic          ie
);

    state_t state;
    state_t state_nxt;
    src_t   src;
    logic   in_isr;
    logic   pending;
    logic   take;
    logic   clr;

    int_edge_latch u_edge (
        .clk     (clk),
        .rst     (rst),
        .intr_in (intr_in),
        .clr     (clr),
        .pending (pending)
    );

    // State register; reset always restarts the boot sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state pulse outputs
    always_comb begin
        state_nxt = state;
        vec_rd    = 1'b0;
        vec_raddr = '0;
        pc_hold   = 1'b0;
        int_sig   = 1'b0;
        flush     = 1'b0;
        flags_rst = 1'b0;
        take      = 1'b0;
        clr       = 1'b0;
        case (state)
            ST_BOOT: begin
                vec_rd    = 1'b1;
                vec_raddr = RST_VADDR;
                pc_hold   = 1'b1;
                state_nxt = ST_VWAIT;
            end
            ST_IDLE: begin
                // An enabled request outranks RTI; both cannot coexist since ie=0 inside the ISR
                if (pending && ie && !stall && !branch_pend) begin
                    take      = 1'b1;
                    state_nxt = ST_FETCH;
                end else if (rti && in_isr) begin
                    state_nxt = ST_RETURN;
                end
            end
            ST_FETCH: begin
                vec_rd    = 1'b1;
                vec_raddr = INT_VADDR;
                pc_hold   = 1'b1;
                state_nxt = ST_VWAIT;
            end
            ST_VWAIT: begin
                pc_hold   = 1'b1;
                state_nxt = ST_REDIR;
            end
            ST_REDIR: begin
                int_sig   = 1'b1;
                flush     = 1'b1;
                clr       = (src == SRC_INT);
                state_nxt = ST_IDLE;
            end
            ST_RETURN: begin
                flags_rst = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    // Save registers, vector capture and the enable / in-service bits
    always_ff @(posedge clk) begin
        if (rst) begin
            src       <= SRC_BOOT;
            ie        <= 1'b0;
            in_isr    <= 1'b0;
            int_vec   <= '0;
            ret_pc    <= '0;
            flags_out <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    src <= SRC_BOOT;
                end
                ST_IDLE: begin
                    if (take) begin
                        ret_pc    <= pc_next;
                        flags_out <= flags_in;
                        src       <= SRC_INT;
                    end
                end
                ST_VWAIT: begin
                    int_vec <= vec_rdata;
                end
                ST_REDIR: begin
                    if (src == SRC_BOOT) begin
                        ie <= 1'b1;
                    end else begin
                        ie     <= 1'b0;
                        in_isr <= 1'b1;
                    end
                end
                ST_RETURN: begin
                    ie     <= 1'b1;
                    in_isr <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
